// File: rtl/mdu_div_pkg.sv
// Shared definitions for the HI/LO divide unit.
// Purpose: divider state encodings, default operand width, HI/LO zero constant.
// Used by: mdu_div_step, mdu_div_unit.
package mdu_div_pkg;

    localparam int DIV_DW = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Same reset/clear value the HI/LO register uses.
    localparam logic [2*DIV_DW-1:0] ZeroDWord = '0;

endpackage

// File: rtl/mdu_div_step.sv
// Purpose: one combinational radix-2 restoring-division step on unsigned magnitudes.
// Latency: combinational.
// Ports: rem/quo/divisor_abs in; rem_next/quo_next out. quo carries the unconsumed
// dividend bits in its upper part and the developed quotient bits in its lower part.
module mdu_div_step
    import mdu_div_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic [DW-1:0] rem,
    input  logic [DW-1:0] quo,
    input  logic [DW-1:0] divisor_abs,
    output logic [DW-1:0] rem_next,
    output logic [DW-1:0] quo_next
);

    logic [DW:0] shifted;
    logic [DW:0] trial;

    // rem < divisor_abs is invariant, so shifted < 2*divisor_abs and a
    // non-negative trial always fits back into DW bits.
    assign shifted = {rem, quo[DW-1]};
    assign trial   = shifted - {1'b0, divisor_abs};

    always_comb begin
        rem_next = shifted[DW-1:0];
        quo_next = {quo[DW-2:0], 1'b0};
        if (!trial[DW]) begin
            rem_next = trial[DW-1:0];
            quo_next = {quo[DW-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_div_unit.sv
// Purpose: iterative restoring DIV/DIVU feeding the HI/LO write port ({HI=rem, LO=quo}).
// Latency: DW+2 cycles from accepted start to the single hilo_wen pulse.
// Flow: stall_req holds EX while working; cancel aborts; start while busy is ignored.
// Option MDU_DIV_ZERO_FAST_EN: divisor==0 skips straight to DONE with raw {dividend, all-ones}.
// Ports: clk, rst (async, active-high); start/signed_op/dividend/divisor/cancel in;
// stall_req/busy/done/hilo_wen/hilo_wdata out.
module mdu_div_unit
    import mdu_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int CW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic [DW-1:0]   dividend,
    input  logic [DW-1:0]   divisor,
    input  logic            cancel,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic            hilo_wen,
    output logic [2*DW-1:0] hilo_wdata
);

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam bit FastZero = 1'b1;
`else
    localparam bit FastZero = 1'b0;
`endif

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rem_q, quo_q, dvs_q;
    logic          quo_neg_q, rem_neg_q;

    logic          a_neg, b_neg, accept, div_zero;
    logic [DW-1:0] a_abs, b_abs;
    logic [DW-1:0] step_rem, step_quo;

    assign a_neg    = signed_op & dividend[DW-1];
    assign b_neg    = signed_op & divisor[DW-1];
    assign a_abs    = a_neg ? -dividend : dividend;
    assign b_abs    = b_neg ? -divisor  : divisor;
    assign accept   = (state_q == DIV_IDLE) && start && !cancel;
    assign div_zero = (divisor == '0);

    mdu_div_step #(.DW(DW)) u_step (
        .rem         (rem_q),
        .quo         (quo_q),
        .divisor_abs (dvs_q),
        .rem_next    (step_rem),
        .quo_next    (step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                stall_req = start;
                if (accept) begin
                    state_d = (FastZero && div_zero) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                stall_req = 1'b1;
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else if (cnt_q == CW'(DW-1)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                stall_req = 1'b1;
                state_d   = cancel ? DIV_IDLE : DIV_DONE;
            end
            DIV_DONE: begin
                // Instruction advances in the same cycle HI/LO is written.
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign busy     = (state_q != DIV_IDLE);
    assign done     = (state_q == DIV_DONE) && !cancel;
    assign hilo_wen = done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            hilo_wdata <= ZeroDWord[2*DW-1:0];
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= a_abs;
                        dvs_q     <= b_abs;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (FastZero && div_zero) begin
                            hilo_wdata <= {dividend, {DW{1'b1}}};
                        end
                    end
                end
                DIV_CALC: begin
                    if (!cancel) begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DIV_FIX: begin
                    if (!cancel) begin
                        hilo_wdata <= {rem_neg_q ? -rem_q : rem_q,
                                       quo_neg_q ? -quo_q : quo_q};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_unit.sv
// Bench for mdu_div_unit: random and directed DIV/DIVU operations with
// cancel, reset and busy-start cases, checked every cycle against a
// cycle-count/arithmetic reference model.
module tb_mdu_div_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          signed_op = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          cancel = 1'b0;
    logic          stall_req, busy, done, hilo_wen;
    logic [2*DW-1:0] hilo_wdata;

    int n_checks = 0;
    int n_err = 0;

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mdu_div_unit #(.DW(DW), .CW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .stall_req  (stall_req),
        .busy       (busy),
        .done       (done),
        .hilo_wen   (hilo_wen),
        .hilo_wdata (hilo_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) begin
            if (FAST) return {a, 32'hFFFF_FFFF};
            // Quotient all-ones then sign fixup; remainder = dividend.
            if (s && a[31]) return {a, 32'h0000_0001};
            return {a, 32'hFFFF_FFFF};
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Model: m_left = clock edges remaining until the done cycle.
    bit          m_active = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_hilo = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_left   = 0;
            m_hilo   = '0;
        end else if (!m_active) begin
            if (start && !cancel) begin
                m_active = 1'b1;
                m_res    = ref_div(signed_op, dividend, divisor);
                if (FAST && divisor == 0) begin
                    m_left = 0;
                    m_hilo = m_res;
                end else begin
                    m_left = DW + 1;
                end
            end
        end else if (cancel || m_left == 0) begin
            m_active = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) m_hilo = m_res;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic exp_done, exp_stall;
        exp_done  = m_active && m_left == 0 && !cancel;
        exp_stall = m_active ? (m_left != 0) : start;
        chk("ctrl{busy,done,wen,stall}", {60'b0, busy, done, hilo_wen, stall_req},
            {60'b0, m_active, exp_done, exp_done, exp_stall});
        chk("hilo_wdata", hilo_wdata, m_hilo);
    end

    // Runs one operation; optional cancel/reset/second-start at a given cycle.
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int rst_at, input int poke_at,
                          output logic [63:0] res, output int lat, output int stall_gaps);
        res = '0;
        lat = -1;
        stall_gaps = 0;
        @(posedge clk);
        #1;
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        #1;
        if (!stall_req) stall_gaps++;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cancel = 1'b0;
            rst = 1'b0;
            if (hilo_wen) begin
                lat = i;
                res = hilo_wdata;
                break;
            end
            if (!stall_req) stall_gaps++;
            if (i == cancel_at) cancel = 1'b1;
            if (i == poke_at) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd2;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", {63'b0, busy}, 64'd0);
                chk("rst_hilo", hilo_wdata, 64'd0);
            end
        end
        start = 1'b0;
        cancel = 1'b0;
        rst = 1'b0;
    endtask

    logic [63:0] res;
    int          lat, gaps;
    int          exp_lat;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_wen", {63'b0, hilo_wen}, 64'd0);
        chk("reset_hilo", hilo_wdata, 64'd0);
        rst = 1'b0;

        // Pin the model with hand-computed values.
        chk("model_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        chk("model_div_m7_2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_div_ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

        // Directed.
        run_op(1'b0, 32'd100, 32'd7, -1, -1, -1, res, lat, gaps);
        chk("divu_100_7", res, 64'h00000002_0000000E);
        chk("divu_100_7_lat", 64'(lat), 64'(34));
        chk("divu_100_7_stall_gaps", 64'(gaps), 64'd0);

        run_op(1'b1, 32'hFFFFFFF9, 32'd2, -1, -1, -1, res, lat, gaps);
        chk("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, -1, -1, -1, res, lat, gaps);
        chk("div_7_m2", res, 64'h00000001_FFFFFFFD);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, -1, -1, res, lat, gaps);
        chk("div_ovf", res, 64'h00000000_80000000);

        run_op(1'b0, 32'h12345678, 32'd0, -1, -1, -1, res, lat, gaps);
        chk("divu_by_zero", res, 64'h12345678_FFFFFFFF);
        chk("divu_by_zero_lat", 64'(lat), FAST ? 64'd1 : 64'd34);

        // Cancel mid-calculation, then a clean operation.
        run_op(1'b0, 32'd50, 32'd3, 10, -1, -1, res, lat, gaps);
        chk("cancel_no_wen", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(1'b0, 32'd40, 32'd6, -1, -1, -1, res, lat, gaps);
        chk("after_cancel_40_6", res, 64'h00000004_00000006);

        // Reset mid-operation.
        run_op(1'b1, 32'd1234, 32'd5, -1, 5, -1, res, lat, gaps);
        chk("rst_no_wen", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

        // Start while busy is ignored.
        run_op(1'b0, 32'd1000, 32'd10, -1, -1, 5, res, lat, gaps);
        chk("busy_start_ignored", res, 64'h00000000_00000064);

        // start together with cancel in IDLE is not accepted.
        @(posedge clk);
        #1;
        start = 1'b1; cancel = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_idle", {63'b0, busy}, 64'd0);

        // Randomized operations.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a, b;
            bit s;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2, 3: begin
                    b = 32'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: b = $urandom;
            endcase
            exp_lat = (FAST && b == 0) ? 1 : 34;
            run_op(s, a, b, -1, -1, -1, res, lat, gaps);
            chk("rand_result", res, ref_div(s, a, b));
            chk("rand_lat", 64'(lat), 64'(exp_lat));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
